mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O responder for the single-cycle MIPS CPU; the target end of the IORead/IOWrite strobes the controller asserts for lw/sw to 0xFFFFFC00-0xFFFFFFFF.
- Holds the LED and 7-segment registers, drives the 8-digit display scan, synchronises and debounces the switches and confirm button, and runs a millisecond timer.
- Sits beside data memory; its io_rdata joins the MemorIOtoReg write-back mux.

Parameters:
- DEB_CYCLES, 20000: cycles an input must be stable before its debounced value updates.
- SCAN_DIV, 50000: cycles each 7-seg digit stays selected.
- TICK_CYCLES, 100000: clock cycles per timer millisecond.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low; one clock; no other clock domains.
- IORead  in  1  lw to the I/O region this cycle.
- IOWrite  in  1  sw to the I/O region this cycle.
- addr  in  8  ALU result [7:0], byte offset within the I/O page.
- wdata  in  32  store data (rt).
- io_rdata  out  32  read data, combinational.
- switch_in  in  24  raw board switches, asynchronous.
- btn_in  in  1  raw confirm button, asynchronous, active-high.
- led  out  24  LED drive, active-high.
- seg_an  out  8  digit select, active-low, one-hot-zero.
- seg_cat  out  8  segments {dp,g..a}, active-low.

Behaviour:
- Register map (addr), all word-aligned. addr[1:0] is ignored.
  - 0x00 LED: R/W. Bits [23:0] are stored; reads return zero-extended.
  - 0x10 SW: RO. Returns the 24-bit debounced switches, zero-extended.
  - 0x20 SEG: R/W. 32 bits, one hex nibble per digit; nibble 0 is digit 0 (rightmost).
  - 0x30 TIMER: R/W. Reads return the ms count. A write of any value clears it to 0.
  - 0x40 BTN: RO. Bit0 is the sticky press flag, bit1 the debounced level, other bits 0.
  - Other addresses read 0 and ignore writes.
- Writes take effect at the clock edge where IOWrite=1. A read in the following cycle returns the new value.
- io_rdata is driven from addr whenever IORead=1, and is 0 when IORead=0. This gives zero latency for the write-back mux.
- Read side effect: at the edge where IORead=1 and addr=0x40, the sticky flag clears.
  - If a new press rising edge occurs in that same cycle, the flag stays 1 (set wins).
- IORead and IOWrite are mutually exclusive by decode. If both are asserted, the write happens and io_rdata still reflects the pre-edge value.
- Input path, per switch bit and the button:
  - Two-flop synchroniser, then a debounce counter.
  - The counter resets whenever the synced value differs from the debounced value.
  - When the counter reaches DEB_CYCLES-1 while they still differ, the debounced value takes the synced value.
  - A glitch shorter than DEB_CYCLES never propagates.
- Button press: a 0->1 transition of the debounced button sets the sticky flag.
- Timer:
  - The prescaler counts 0..TICK_CYCLES-1.
  - On wrap, the 32-bit ms count increments. 0xFFFFFFFF wraps to 0.
  - A TIMER write clears both the ms count and the prescaler. A clear in the same cycle as a tick wins.
- Scan:
  - The divider counts 0..SCAN_DIV-1; the digit index (3-bit) increments on wrap, 7 -> 0.
  - seg_an = ~(1<<idx).
  - seg_cat is the active-low hex decode of the nibble at SEG[idx*4+:4], with the dp segment off (1).
  - seg_an and seg_cat are both registered so they change on the same edge.
- Reset (reset=0 at an edge) clears:
  - led=0, SEG=0, ms count and prescaler=0, sticky flag=0.
  - Debounced values = 0, synchroniser flops = 0, debounce counters = 0.
  - Scan idx=0, divider=0, seg_an=8'hFE, seg_cat=8'hC0 (shows "0").
  - Reset mid-operation abandons any pending debounce or tick.

Decomposition:
- Shared package io_map_pkg holds:
  - the offset constants (IO_LED=8'h00, IO_SW=8'h10, IO_SEG=8'h20, IO_TIMER=8'h30, IO_BTN=8'h40);
  - the I/O page base 22'h3FFFFF;
  - the hex-to-segment table.
- One sub-module, io_debounce (parameter WIDTH, DEB_CYCLES): synchroniser plus debounce. It is instantiated twice, for 24 switches and for 1 button.

Test Plan:
- Run with DEB_CYCLES=4, SCAN_DIV=3, TICK_CYCLES=5.
- Reset: hold reset=0 for 2 cycles -> led=0, seg_an=FE, seg_cat=C0; read 0x30 -> 0; read 0x40 -> 0.
- LED write/read: IOWrite addr=0x00 wdata=FFABCDEF -> led=ABCDEF next cycle; IORead 0x00 -> 00ABCDEF; IORead addr=0x50 -> 0.
- Switch debounce:
  - switch_in=000005 held -> read 0x10 is 0 until 2+4 cycles have elapsed, then 00000005.
  - A 2-cycle pulse to 000001 never appears.
- Button sticky: press held 10 cycles -> read 0x40 = 3. Release, then read again -> 0.
  - A press edge coinciding with the clearing read -> the next read returns bit0=1.
- Timer: after 25 cycles, read 0x30 = 5. Write 0x30 on a tick cycle -> the next read is 0.
- Scan: write SEG=76543210 -> seg_an steps FE,FD,...,7F every 3 cycles, and seg_cat on digit 1 = F9 ("1"). After digit 7, seg_an returns to FE.

Source files
------------

// File: rtl/io_map_pkg.sv
// I/O page map shared by the MMIO responder and its neighbours.
// Holds the register offsets, the I/O page base (address bits [31:10])
// and the hex-to-7-segment decode (active-low, {dp,g..a}, dp off).
package io_map_pkg;

  localparam logic [7:0]  IO_LED       = 8'h00;
  localparam logic [7:0]  IO_SW        = 8'h10;
  localparam logic [7:0]  IO_SEG       = 8'h20;
  localparam logic [7:0]  IO_TIMER     = 8'h30;
  localparam logic [7:0]  IO_BTN       = 8'h40;
  localparam logic [21:0] IO_PAGE_BASE = 22'h3FFFFF;

  // True when a full byte address falls in the I/O page.
  function automatic logic in_io_page(input logic [31:0] byte_addr);
    return byte_addr[31:10] == IO_PAGE_BASE;
  endfunction

  // Active-low hex digit decode with the decimal point dark.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    logic [7:0] seg;
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a per-bit debounce counter.
// Ports:
//   clock, reset (sync, active-low)
//   din  [WIDTH] raw asynchronous inputs
//   dout [WIDTH] debounced, registered
// A bit's debounced value follows its synced value only after the two
// have disagreed for DEB_CYCLES consecutive cycles.
module io_debounce #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      dout  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        // Any agreement restarts the stability window.
        if (sync2[i] != dout[i]) begin
          if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
            dout[i] <= sync2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O responder for the single-cycle MIPS CPU.
// Ports:
//   clock, reset (sync, active-low)
//   IORead, IOWrite   strobes for lw/sw into the I/O page
//   addr  [8]         byte offset in the page (bits [1:0] ignored)
//   wdata [32]        store data
//   io_rdata [32]     combinational read data, 0 when IORead=0
//   switch_in [24], btn_in   raw asynchronous board inputs
//   led [24]          LED drive, active-high
//   seg_an [8], seg_cat [8]  registered 7-seg scan, active-low
module mmio_io_ctrl
  import io_map_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 20000,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned TICK_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IORead,
  input  logic        IOWrite,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] io_rdata,
  input  logic [23:0] switch_in,
  input  logic        btn_in,
  output logic [23:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [23:0]       sw_deb;
  logic              btn_deb;
  logic              btn_prev;
  logic              sticky;
  logic [31:0]       seg_q;
  logic [31:0]       ms_cnt;
  logic [TICK_W-1:0] pre_cnt;
  logic [SCAN_W-1:0] scan_div;
  logic [2:0]        scan_idx;

  logic [7:0]        word;
  logic              wr_led, wr_seg, wr_timer, rd_btn, btn_rise;
  logic [31:0]       seg_nxt;
  logic [SCAN_W-1:0] div_nxt;
  logic [2:0]        idx_nxt;

  io_debounce #(.WIDTH(24), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
    .clock (clock),
    .reset (reset),
    .din   (switch_in),
    .dout  (sw_deb)
  );

  io_debounce #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
    .clock (clock),
    .reset (reset),
    .din   (btn_in),
    .dout  (btn_deb)
  );

  // Address decode on the word offset.
  always_comb begin
    word     = addr & 8'hFC;
    wr_led   = IOWrite && (word == IO_LED);
    wr_seg   = IOWrite && (word == IO_SEG);
    wr_timer = IOWrite && (word == IO_TIMER);
    rd_btn   = IORead  && (word == IO_BTN);
    btn_rise = btn_deb && !btn_prev;
  end

  // Zero-latency read mux feeding the write-back path.
  always_comb begin
    io_rdata = 32'h0;
    if (IORead) begin
      case (word)
        IO_LED:   io_rdata = {8'h00, led};
        IO_SW:    io_rdata = {8'h00, sw_deb};
        IO_SEG:   io_rdata = seg_q;
        IO_TIMER: io_rdata = ms_cnt;
        IO_BTN:   io_rdata = {30'h0, btn_deb, sticky};
        default:  io_rdata = 32'h0;
      endcase
    end
  end

  // Scan next state; the registered drive is built from it so anode
  // and cathode switch together and a SEG write shows immediately.
  always_comb begin
    seg_nxt = wr_seg ? wdata : seg_q;
    div_nxt = scan_div + SCAN_W'(1);
    idx_nxt = scan_idx;
    if (scan_div == SCAN_W'(SCAN_DIV - 1)) begin
      div_nxt = '0;
      idx_nxt = scan_idx + 3'd1;
    end
  end

  // Registers, button flag and display drive.
  always_ff @(posedge clock) begin
    if (!reset) begin
      led      <= '0;
      seg_q    <= '0;
      btn_prev <= 1'b0;
      sticky   <= 1'b0;
      scan_div <= '0;
      scan_idx <= '0;
      seg_an   <= 8'hFE;
      seg_cat  <= 8'hC0;
    end else begin
      if (wr_led) led <= wdata[23:0];
      seg_q    <= seg_nxt;
      btn_prev <= btn_deb;
      // A new press beats the clearing read.
      if (btn_rise)    sticky <= 1'b1;
      else if (rd_btn) sticky <= 1'b0;
      scan_div <= div_nxt;
      scan_idx <= idx_nxt;
      seg_an   <= ~(8'd1 << idx_nxt);
      seg_cat  <= hex_to_seg(seg_nxt[{idx_nxt, 2'b00} +: 4]);
    end
  end

  // Millisecond timer; a TIMER write beats a coincident tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ms_cnt  <= '0;
      pre_cnt <= '0;
    end else if (wr_timer) begin
      ms_cnt  <= '0;
      pre_cnt <= '0;
    end else if (pre_cnt == TICK_W'(TICK_CYCLES - 1)) begin
      pre_cnt <= '0;
      ms_cnt  <= ms_cnt + 32'd1;
    end else begin
      pre_cnt <= pre_cnt + TICK_W'(1);
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
module tb_mmio_io_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned SD  = 3;
  localparam int unsigned TK  = 5;

  logic        clock = 1'b0;
  logic        reset, IORead, IOWrite, btn_in;
  logic [7:0]  addr, seg_an, seg_cat;
  logic [31:0] wdata, io_rdata;
  logic [23:0] switch_in, led;

  always #5 clock = ~clock;

  mmio_io_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SD), .TICK_CYCLES(TK)) dut (
    .clock     (clock),
    .reset     (reset),
    .IORead    (IORead),
    .IOWrite   (IOWrite),
    .addr      (addr),
    .wdata     (wdata),
    .io_rdata  (io_rdata),
    .switch_in (switch_in),
    .btn_in    (btn_in),
    .led       (led),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: elapsed-cycle counters and a per-bit stability run.
  logic [23:0] m_led;
  logic [31:0] m_seg;
  longint      m_tcnt;   // cycles since reset / last TIMER write
  longint      m_scnt;   // cycles since reset
  logic [24:0] m_s1, m_s2, m_deb;
  int          m_run [25];
  logic        m_prev, m_sticky;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic rd, input logic [7:0] a);
    if (!rd) return 32'h0;
    case (a & 8'hFC)
      8'h00:   return {8'h00, m_led};
      8'h10:   return {8'h00, m_deb[23:0]};
      8'h20:   return m_seg;
      8'h30:   return 32'(m_tcnt / longint'(TK));
      8'h40:   return {30'h0, m_deb[24], m_sticky};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_seg = '0; m_tcnt = 0; m_scnt = 0;
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = 1'b0; m_sticky = 1'b0;
    for (int b = 0; b < 25; b++) m_run[b] = 0;
  endtask

  task automatic model_edge(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [31:0] d, input logic [24:0] raw);
    logic rise;
    rise = m_deb[24] && !m_prev;
    if (rise) m_sticky = 1'b1;
    else if (rd && ((a & 8'hFC) == 8'h40)) m_sticky = 1'b0;
    m_prev = m_deb[24];
    for (int b = 0; b < 25; b++) begin
      if (m_s2[b] !== m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(DEB)) begin
          m_deb[b] = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    if (wr && ((a & 8'hFC) == 8'h00)) m_led = d[23:0];
    if (wr && ((a & 8'hFC) == 8'h20)) m_seg = d;
    if (wr && ((a & 8'hFC) == 8'h30)) m_tcnt = 0;
    else m_tcnt++;
    m_scnt++;
  endtask

  // One clock: drive, check read data, clock, check registered outputs.
  task automatic cycle(input logic rst, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic cchk = 1'b0, input logic [31:0] cexp = 32'h0);
    int         idx;
    logic [7:0] an;
    reset = rst; IORead = rd; IOWrite = wr; addr = a; wdata = d;
    #1;
    check("rdata", io_rdata, exp_rdata(rd, a));
    if (cchk) check("rdata_directed", io_rdata, cexp);
    @(posedge clock);
    if (!rst) model_reset();
    else model_edge(rd, wr, a, d, {btn_in, switch_in});
    #1;
    idx = int'((m_scnt / longint'(SD)) % 8);
    an  = ~(8'd1 << idx);
    check("led", 32'(led), 32'(m_led));
    check("seg_an", 32'(seg_an), 32'(an));
    check("seg_cat", 32'(seg_cat), 32'(seg_tab[m_seg[idx*4 +: 4]]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic rd_expect(input logic [7:0] a, input logic [31:0] e);
    cycle(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, e);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    logic       found;
    logic [7:0] pick [7];
    logic       rd, wr, rst;
    logic [7:0] a;

    switch_in = '0; btn_in = 1'b0;
    model_reset();

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_seg_an", 32'(seg_an), 32'hFE);
    check("rst_seg_cat", 32'(seg_cat), 32'hC0);
    rd_expect(8'h30, 32'h0);
    rd_expect(8'h40, 32'h0);

    // LED write/read and unmapped read
    wr_reg(8'h00, 32'hFFABCDEF);
    check("led_written", 32'(led), 32'h00ABCDEF);
    rd_expect(8'h00, 32'h00ABCDEF);
    rd_expect(8'h50, 32'h0);
    wr_reg(8'h50, 32'h12345678);
    rd_expect(8'h50, 32'h0);

    // Switch glitch is filtered, held value appears after 2+DEB edges
    switch_in = 24'h000001;
    idle(2);
    switch_in = 24'h000000;
    idle(8);
    rd_expect(8'h10, 32'h0);
    switch_in = 24'h000005;
    idle(5);
    rd_expect(8'h10, 32'h0);
    rd_expect(8'h10, 32'h00000005);

    // Button sticky flag
    btn_in = 1'b1;
    idle(10);
    rd_expect(8'h40, 32'h3);
    btn_in = 1'b0;
    idle(8);
    rd_expect(8'h40, 32'h0);
    // Press edge lands in the same cycle as the clearing read
    btn_in = 1'b1;
    idle(6);
    rd_expect(8'h40, 32'h2);
    rd_expect(8'h40, 32'h3);
    btn_in = 1'b0;
    idle(8);

    // Timer
    wr_reg(8'h30, 32'hDEADBEEF);
    idle(25);
    rd_expect(8'h30, 32'h5);
    idle(3);                      // prescaler now at its last count
    wr_reg(8'h30, 32'h0);
    rd_expect(8'h30, 32'h0);

    // Scan
    wr_reg(8'h20, 32'h76543210);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (seg_an == 8'hFD) found = 1'b1;
      else idle(1);
    end
    check("scan_reach_digit1", 32'(found), 32'h1);
    check("scan_digit1_cat", 32'(seg_cat), 32'hF9);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (seg_an == 8'h7F) found = 1'b1;
      else idle(1);
    end
    check("scan_reach_digit7", 32'(found), 32'h1);
    check("scan_digit7_cat", 32'(seg_cat), 32'hF8);
    idle(3);
    check("scan_wrap", 32'(seg_an), 32'hFE);

    // Randomised traffic against the model
    pick = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00};
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) switch_in = 24'($urandom);
      if ($urandom_range(0, 5) == 0) btn_in = ~btn_in;
      rst = ($urandom_range(0, 149) != 0);
      rd  = ($urandom_range(0, 1) == 1);
      wr  = ($urandom_range(0, 3) == 0);
      a   = pick[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) a = 8'($urandom);
      a   = a | 8'($urandom_range(0, 3));
      cycle(rst, rd, wr, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
